// File: rtl/cv32e41s_tcm_obi_bridge.sv
// cv32e41s_tcm_obi_bridge
// Bridges an OBI data port onto a single-port, read-first, 1-cycle-latency
// word RAM. Reads and full-word writes complete at one grant per cycle.
// Partial writes take two cycles: a read of the old word, then a merged write.
// Requests beyond MEM_SIZE words get an error response without a RAM access.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i     OBI request channel
//   rvalid_o/rdata_o/err_o            OBI response channel
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i   RAM port
module cv32e41s_tcm_obi_bridge #(
    parameter int unsigned A_WID    = 32,
    parameter int unsigned MEM_SIZE = 4096,
    parameter int unsigned D_WID    = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               req_i,
    output logic               gnt_o,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [D_WID-1:0]   wdata_i,
    output logic               rvalid_o,
    output logic [D_WID-1:0]   rdata_o,
    output logic               err_o,

    output logic               mem_en_o,
    output logic               mem_we_o,
    output logic [A_WID-1:0]   mem_addr_o,
    output logic [D_WID-1:0]   mem_wdata_o,
    input  logic [D_WID-1:0]   mem_rdata_i
);

    localparam int unsigned NB = D_WID / 8;

    typedef enum logic {
        ACCEPT = 1'b0,
        MERGE  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_read_q, rsp_read_d;
    logic [A_WID-1:0]   addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [D_WID-1:0]   wdata_q, wdata_d;

    logic [29:0]        word_idx;
    logic               oor;
    logic [D_WID-1:0]   merged;
    logic               unused_addr_lsb;

    // Byte offset is irrelevant to a word RAM.
    assign word_idx        = addr_i[31:2];
    assign unused_addr_lsb = ^addr_i[1:0];
    assign oor             = 32'(word_idx) >= MEM_SIZE;

    // Overlay latched write bytes onto the old word read in the grant cycle.
    always_comb begin
        merged = mem_rdata_i;
        for (int b = 0; b < NB; b++) begin
            if (be_q[b]) begin
                merged[b*8 +: 8] = wdata_q[b*8 +: 8];
            end
        end
    end

    // Next state, RAM port and grant.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_read_d  = 1'b0;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        gnt_o       = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        unique case (state_q)
            ACCEPT: begin
                if (req_i) begin
                    gnt_o = 1'b1;
                    if (oor) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!we_i) begin
                        mem_en_o    = 1'b1;
                        mem_addr_o  = A_WID'(word_idx);
                        rsp_valid_d = 1'b1;
                        rsp_read_d  = 1'b1;
                    end else if (be_i == 4'hF) begin
                        mem_en_o    = 1'b1;
                        mem_we_o    = 1'b1;
                        mem_addr_o  = A_WID'(word_idx);
                        mem_wdata_o = wdata_i;
                        rsp_valid_d = 1'b1;
                    end else if (be_i == 4'h0) begin
                        rsp_valid_d = 1'b1;
                    end else begin
                        // Partial write: fetch old word, finish in MERGE.
                        mem_en_o   = 1'b1;
                        mem_addr_o = A_WID'(word_idx);
                        addr_d     = A_WID'(word_idx);
                        be_d       = be_i;
                        wdata_d    = wdata_i;
                        state_d    = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = merged;
                rsp_valid_d = 1'b1;
                state_d     = ACCEPT;
            end
            default: begin
                state_d = ACCEPT;
            end
        endcase

        // Reset silences the port immediately, aborting any merge write.
        if (rst_i) begin
            gnt_o       = 1'b0;
            mem_en_o    = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
        end
    end

    // State and pending-response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ACCEPT;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_read_q  <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_read_q  <= rsp_read_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
        end
    end

    // Response: read data passes straight through from the RAM.
    assign rvalid_o = rsp_valid_q && !rst_i;
    assign err_o    = rvalid_o && rsp_err_q;
    assign rdata_o  = (rvalid_o && rsp_read_q) ? mem_rdata_i : '0;

endmodule

// File: doc/cv32e41s_tcm_obi_bridge.md
CV32E41S_TCM_OBI_BRIDGE -- requirements
Module: cv32e41s_tcm_obi_bridge

Interface
REQ-001 SHALL have parameter A_WID, default 32, meaning word-address width driven to the RAM port.
REQ-002 SHALL have parameter MEM_SIZE, default 4096, meaning the number of 32-bit words in the attached RAM.
REQ-003 SHALL have parameter D_WID, default 32, meaning the data width; only 32 is supported.
REQ-004 clk_i  in  1  single clock; all logic on posedge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 req_i  in  1  OBI request valid.
REQ-007 gnt_o  out  1  OBI grant.
REQ-008 addr_i  in  32  OBI byte address.
REQ-009 we_i  in  1  OBI write enable.
REQ-010 be_i  in  4  OBI byte enables.
REQ-011 wdata_i  in  32  OBI write data.
REQ-012 rvalid_o  out  1  OBI response valid.
REQ-013 rdata_o  out  32  OBI response data.
REQ-014 err_o  out  1  OBI response error, qualified by rvalid_o.
REQ-015 mem_en_o  out  1  RAM port enable.
REQ-016 mem_we_o  out  1  RAM port write enable.
REQ-017 mem_addr_o  out  A_WID  RAM word address.
REQ-018 mem_wdata_o  out  32  RAM write data.
REQ-019 mem_rdata_i  in  32  RAM read data; valid 1 cycle after mem_en_o=1 with mem_we_o=0; read-first.

Function
REQ-020 The FSM SHALL have two states: ACCEPT and MERGE.
REQ-021 gnt_o SHALL be combinational: req_i && state==ACCEPT.
REQ-022 Word index SHALL be addr_i[31:2]; addr_i[1:0] SHALL be ignored.
REQ-023 A request SHALL be out-of-range when the word index >= MEM_SIZE.
REQ-024 Out-of-range granted request, in the cycle after grant: rvalid_o=1, err_o=1, rdata_o=0; no mem_en_o.
REQ-025 Read grant SHALL drive mem_en_o=1, mem_we_o=0 in the grant cycle.
REQ-026 Read response, in the cycle after grant: rvalid_o=1, err_o=0, rdata_o=mem_rdata_i; rdata_o SHALL be combinational from mem_rdata_i.
REQ-027 Full write grant (be_i=4'hF) SHALL drive mem_en_o=1, mem_we_o=1, mem_wdata_o=wdata_i in the grant cycle.
REQ-028 Full write response, in the cycle after grant: rvalid_o=1, rdata_o=0.
REQ-029 Empty write (be_i=0) SHALL perform no RAM access; rvalid_o=1 in the cycle after grant.
REQ-030 Partial write grant SHALL read the word (mem_en_o=1, mem_we_o=0), latch address, be_i and wdata_i, and go to MERGE.
REQ-031 In MERGE: mem_en_o=1, mem_we_o=1, latched address.
REQ-032 In MERGE, for each byte b: mem_wdata_o byte b = wdata byte b if be[b]=1, else mem_rdata_i byte b.
REQ-033 In MERGE: gnt_o=0, rvalid_o=0; the next state SHALL be ACCEPT.
REQ-034 Partial write response SHALL be in the cycle after MERGE: rvalid_o=1, rdata_o=0.
REQ-035 Reads and full writes SHALL sustain 1 grant/cycle; a grant and the previous response may coincide.
REQ-036 Outputs SHALL be 0 whenever no access or response is active; mem_addr_o/mem_wdata_o are don't-care when mem_en_o=0.
REQ-037 A read granted in the cycle after a completed write to the same word (full-write grant cycle or MERGE) SHALL return the new data; no extra stall SHALL be inserted.
REQ-038 At most one response SHALL be outstanding; responses SHALL be in grant order.

Reset
REQ-039 rst_i=1 SHALL force ACCEPT and clear the latched request and response-pending flags.
REQ-040 During reset: gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, mem_en_o=0, mem_we_o=0.
REQ-041 Reset during MERGE SHALL abort the merge; no RAM write and no response SHALL follow.
REQ-042 A response pending at reset SHALL be dropped.

Verification
REQ-043 Full write 0xDEADBEEF to 0x10, then a back-to-back read of 0x10 -> grants in consecutive cycles; read rvalid_o carries 0xDEADBEEF with err_o=0.
REQ-044 Word 0x20 = 0x11223344; write be=4'b0101, wdata=0xAABBCCDD -> gnt_o low in the MERGE cycle; mem_wdata_o=0x11BB33DD; response 2 cycles after grant; read-back 0x11BB33DD.
REQ-045 Read of addr 0x4000 (word 4096, MEM_SIZE=4096) -> rvalid_o=1, err_o=1, rdata_o=0; mem_en_o never asserted.
REQ-046 Write with be=0 to 0x8 -> rvalid_o next cycle; mem_en_o stays 0; word 0x8 unchanged.
REQ-047 rst_i asserted in the MERGE cycle of a partial write to 0x30 -> no mem_we_o at the reset edge, no rvalid_o; word 0x30 keeps its old value.
REQ-048 Stream of 8 reads with req_i held high -> 8 consecutive grants and 8 consecutive rvalid_o pulses, each 1 cycle after its grant.
